// File: rtl/snake_pkg.sv
// Shared state encoding and direction codes for the snake game-control slice.
package snake_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DIR_W   = 4;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned NUM_BTN = 5;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PLAY  = 3'd1;
  localparam logic [2:0] OVER  = 3'd2;
  localparam logic [2:0] WIN   = 3'd3;
  localparam logic [2:0] PAUSE = 3'd4;

  localparam logic [3:0] DIR_STOP = 4'b0000;
  localparam logic [3:0] DIR_L    = 4'b0001;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_U    = 4'b0100;
  localparam logic [3:0] DIR_D    = 4'b1000;

  // Reverse of a committed direction; STOP has no reverse.
  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    case (d)
      DIR_L:   return DIR_R;
      DIR_R:   return DIR_L;
      DIR_U:   return DIR_D;
      DIR_D:   return DIR_U;
      default: return DIR_STOP;
    endcase
  endfunction

  // Simultaneous presses {D,U,R,L} resolve with L > R > U > D.
  function automatic logic [3:0] dir_select(input logic [3:0] presses);
    if (presses[0])      return DIR_L;
    else if (presses[1]) return DIR_R;
    else if (presses[2]) return DIR_U;
    else if (presses[3]) return DIR_D;
    else                 return DIR_STOP;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and one-cycle press pulse.
module btn_debounce
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;

  assign accept_c = (sync_q[1] != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Stable state resets to "pressed" so a button held through reset needs a release first.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= accept_c && sync_q[1];
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (accept_c) begin
        cnt_q    <= '0;
        stable_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game control: button conditioning, move ticks, length and IDLE/PLAY/OVER/WIN sequencing.
// Build option: define PAUSE_EN to add a start-button pause state during play.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned SLOW_DIV        = 25_000_000,
  parameter int unsigned FAST_DIV        = 12_500_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_LENGTH      = 6,
  parameter int unsigned WIN_HOLD_TICKS  = 12
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_start,
  input  logic             sw_level,
  input  logic             head,
  input  logic             apple,
  input  logic             gameOver,
  output logic [DIR_W-1:0] direction,
  output logic [LEN_W-1:0] length,
  output logic             level,
  output logic             over,
  output logic             i_speaker,
  output logic             update_clk,
  output logic             update_clk_fast
);

  localparam int unsigned SLOW_W = $clog2(SLOW_DIV);
  localparam int unsigned FAST_W = $clog2(FAST_DIV);
  localparam int unsigned HOLD_W = $clog2(WIN_HOLD_TICKS + 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw = {btn_start, btn_down, btn_up, btn_right, btn_left};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK100MHZ(CLK100MHZ),
      .reset    (reset),
      .btn      (btn_raw[i]),
      .press    (press[i])
    );
  end

  // Renderer flags and the level switch are asynchronous to this block.
  logic [3:0] flag_meta, flag_sync;
  logic       head_s, apple_s, gameover_s, sw_level_s;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      flag_meta <= 4'b1000;
      flag_sync <= 4'b1000;
    end else begin
      flag_meta <= {sw_level, gameOver, apple, head};
      flag_sync <= flag_meta;
    end
  end

  assign head_s     = flag_sync[0];
  assign apple_s    = flag_sync[1];
  assign gameover_s = flag_sync[2];
  assign sw_level_s = flag_sync[3];

  // Free-running move-tick dividers; the strobe rises on the edge the count wraps to 0.
  logic [SLOW_W-1:0] slow_cnt;
  logic [FAST_W-1:0] fast_cnt;
  logic              slow_wrap_c, fast_wrap_c, active_tick_c;

  assign slow_wrap_c   = (slow_cnt == SLOW_W'(SLOW_DIV - 1));
  assign fast_wrap_c   = (fast_cnt == FAST_W'(FAST_DIV - 1));
  assign active_tick_c = level ? slow_wrap_c : fast_wrap_c;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      slow_cnt        <= '0;
      fast_cnt        <= '0;
      update_clk      <= 1'b0;
      update_clk_fast <= 1'b0;
    end else begin
      slow_cnt        <= slow_wrap_c ? '0 : slow_cnt + SLOW_W'(1);
      fast_cnt        <= fast_wrap_c ? '0 : fast_cnt + FAST_W'(1);
      update_clk      <= slow_wrap_c;
      update_clk_fast <= fast_wrap_c;
    end
  end

  logic [STATE_W-1:0] state, state_d;
  logic [DIR_W-1:0]   cur_dir, cur_dir_d, pending, pending_d, direction_d, move_c;
  logic [LEN_W-1:0]   length_d;
  logic [HOLD_W-1:0]  win_cnt, win_cnt_d;
  logic               eat_q, eat_d, level_d, over_d, speaker_d;
  logic               start_c, eat_c;

  assign start_c = press[4];
  assign eat_c   = head_s & apple_s;
  assign move_c  = dir_select(press[3:0]);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_dir   <= DIR_STOP;
      pending   <= DIR_STOP;
      eat_q     <= 1'b0;
      win_cnt   <= '0;
      direction <= DIR_STOP;
      length    <= '0;
      level     <= 1'b1;
      over      <= 1'b0;
      i_speaker <= 1'b0;
    end else begin
      state     <= state_d;
      cur_dir   <= cur_dir_d;
      pending   <= pending_d;
      eat_q     <= eat_d;
      win_cnt   <= win_cnt_d;
      direction <= direction_d;
      length    <= length_d;
      level     <= level_d;
      over      <= over_d;
      i_speaker <= speaker_d;
    end
  end

  always_comb begin
    state_d     = state;
    cur_dir_d   = cur_dir;
    pending_d   = pending;
    eat_d       = eat_q;
    win_cnt_d   = win_cnt;
    direction_d = direction;
    length_d    = length;
    level_d     = level;
    over_d      = over;
    speaker_d   = i_speaker;

    case (state)
      IDLE: begin
        direction_d = DIR_STOP;
        cur_dir_d   = DIR_STOP;
        length_d    = '0;
        over_d      = 1'b0;
        speaker_d   = 1'b0;
        eat_d       = 1'b0;
        if (start_c) begin
          level_d   = sw_level_s;
          pending_d = DIR_R;
          state_d   = PLAY;
        end
      end

      PLAY: begin
        // Reversal is judged against the committed direction; a tick commits the newest choice.
        if ((move_c != DIR_STOP) && (move_c != dir_opposite(cur_dir))) begin
          pending_d = move_c;
        end
        if (gameover_s) begin
          state_d     = OVER;
          over_d      = 1'b1;
          direction_d = DIR_STOP;
`ifdef PAUSE_EN
        end else if (start_c) begin
          state_d     = PAUSE;
          direction_d = DIR_STOP;
`endif
        end else if (active_tick_c) begin
          cur_dir_d   = pending_d;
          direction_d = pending_d;
          eat_d       = 1'b0;
        end else if (eat_c && !eat_q) begin
          eat_d    = 1'b1;
          length_d = (length == LEN_W'(MAX_LENGTH)) ? length : length + LEN_W'(1);
          if (length_d == LEN_W'(MAX_LENGTH)) begin
            state_d     = WIN;
            speaker_d   = 1'b1;
            direction_d = DIR_STOP;
            win_cnt_d   = '0;
          end
        end
      end

      OVER: begin
        over_d      = 1'b1;
        direction_d = DIR_STOP;
        if (start_c) begin
          state_d  = IDLE;
          over_d   = 1'b0;
          length_d = '0;
        end
      end

      WIN: begin
        speaker_d   = 1'b1;
        direction_d = DIR_STOP;
        if (start_c || (slow_wrap_c && (win_cnt == HOLD_W'(WIN_HOLD_TICKS - 1)))) begin
          state_d   = IDLE;
          speaker_d = 1'b0;
          length_d  = '0;
        end else if (slow_wrap_c) begin
          win_cnt_d = win_cnt + HOLD_W'(1);
        end
      end

      PAUSE: begin
`ifdef PAUSE_EN
        direction_d = DIR_STOP;
        if (start_c) begin
          state_d     = PLAY;
          direction_d = cur_dir;
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scenario bench for snake_game_ctrl with shortened dividers; expectations queued per scenario.
module tb_snake_game_ctrl;

  logic       CLK100MHZ = 1'b0;
  logic       reset;
  logic       btn_left, btn_right, btn_up, btn_down, btn_start;
  logic       sw_level, head, apple, gameOver;
  logic [3:0] direction;
  logic [2:0] length;
  logic       level, over, i_speaker, update_clk, update_clk_fast;

  int checks   = 0;
  int failures = 0;

  logic [3:0] dir_q[$];
  logic [2:0] len_q[$];

  always #5 CLK100MHZ = ~CLK100MHZ;

  snake_game_ctrl #(
    .SLOW_DIV       (8),
    .FAST_DIV       (4),
    .DEBOUNCE_CYCLES(3),
    .MAX_LENGTH     (6),
    .WIN_HOLD_TICKS (2)
  ) dut (
    .CLK100MHZ      (CLK100MHZ),
    .reset          (reset),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_start      (btn_start),
    .sw_level       (sw_level),
    .head           (head),
    .apple          (apple),
    .gameOver       (gameOver),
    .direction      (direction),
    .length         (length),
    .level          (level),
    .over           (over),
    .i_speaker      (i_speaker),
    .update_clk     (update_clk),
    .update_clk_fast(update_clk_fast)
  );

  // mask bits: [0] left [1] right [2] up [3] down [4] start
  task automatic set_btns(input logic [4:0] mask);
    btn_left  = mask[0];
    btn_right = mask[1];
    btn_up    = mask[2];
    btn_down  = mask[3];
    btn_start = mask[4];
  endtask

  task automatic press_btns(input logic [4:0] mask, input int hold);
    @(negedge CLK100MHZ);
    set_btns(mask);
    repeat (hold) @(negedge CLK100MHZ);
    set_btns(5'b0);
    repeat (8) @(negedge CLK100MHZ);
  endtask

  task automatic wait_tick(input bit slow, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK100MHZ);
      if (slow ? update_clk : update_clk_fast) ok = 1'b1;
    end
  endtask

  // Two-cycle head&apple overlap just after a tick, then settle past the increment.
  task automatic eat_pulse(input bit g_over);
    head = 1'b1; apple = 1'b1; gameOver = g_over;
    repeat (2) @(negedge CLK100MHZ);
    head = 1'b0; apple = 1'b0; gameOver = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  task automatic test_reset();
    int slow_n, fast_n, slow_first, fast_first;
    reset = 1'b1; set_btns(5'b0);
    head = 1'b0; apple = 1'b0; gameOver = 1'b0; sw_level = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    checks++;
    if (direction !== 4'b0000 || length !== 3'd0 || level !== 1'b1 || over !== 1'b0 || i_speaker !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: dir=%b len=%0d lvl=%b over=%b spk=%b expected 0000/0/1/0/0",
               direction, length, level, over, i_speaker);
    end
    reset = 1'b0;
    slow_n = 0; fast_n = 0; slow_first = 0; fast_first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK100MHZ);
      if (update_clk) begin slow_n++; if (slow_first == 0) slow_first = i; end
      if (update_clk_fast) begin fast_n++; if (fast_first == 0) fast_first = i; end
    end
    checks++;
    if (slow_first != 8 || slow_n != 2) begin
      failures++;
      $display("FAIL slow_tick: first=%0d count=%0d expected first=8 count=2", slow_first, slow_n);
    end
    checks++;
    if (fast_first != 4 || fast_n != 5) begin
      failures++;
      $display("FAIL fast_tick: first=%0d count=%0d expected first=4 count=5", fast_first, fast_n);
    end
    checks++;
    if (direction !== 4'b0000 || length !== 3'd0) begin
      failures++;
      $display("FAIL idle_outputs: dir=%b len=%0d expected 0000/0", direction, length);
    end
  endtask

  task automatic test_start_fast();
    bit ok;
    logic [3:0] exp;
    sw_level = 1'b0;
    press_btns(5'b10000, 5);
    checks++;
    if (level !== 1'b0) begin
      failures++;
      $display("FAIL start_level: level=%b expected 0", level);
    end
    dir_q.push_back(4'b0010);
    wait_tick(1'b0, ok);
    exp = dir_q.pop_front();
    checks++;
    if (!ok || direction !== exp) begin
      failures++;
      $display("FAIL start_dir: dir=%b expected %b tick=%0b", direction, exp, ok);
    end
    // Two-cycle glitch is shorter than the debounce window
    press_btns(5'b00100, 2);
    dir_q.push_back(4'b0010);
    wait_tick(1'b0, ok);
    exp = dir_q.pop_front();
    checks++;
    if (!ok || direction !== exp) begin
      failures++;
      $display("FAIL glitch_up: dir=%b expected %b tick=%0b", direction, exp, ok);
    end
    press_btns(5'b00100, 5);
    dir_q.push_back(4'b0100);
    wait_tick(1'b0, ok);
    exp = dir_q.pop_front();
    checks++;
    if (!ok || direction !== exp) begin
      failures++;
      $display("FAIL press_up: dir=%b expected %b tick=%0b", direction, exp, ok);
    end
  endtask

  task automatic test_reverse();
    bit ok;
    logic [3:0] exp;
    logic [4:0] masks[5] = '{5'b00010, 5'b00001, 5'b00100, 5'b00001, 5'b00011};
    logic [3:0] dirs[5]  = '{4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      press_btns(masks[i], 5);
      dir_q.push_back(dirs[i]);
      wait_tick(1'b0, ok);
      exp = dir_q.pop_front();
      checks++;
      if (!ok || direction !== exp) begin
        failures++;
        $display("FAIL reverse_step%0d: dir=%b expected %b tick=%0b", i, direction, exp, ok);
      end
    end
  endtask

  task automatic test_eat_win();
    bit ok, win_seen;
    int win_ticks;
    logic [2:0] exp, len_at_win;
    logic [3:0] dir_at_win;
    for (int n = 1; n <= 5; n++) begin
      len_q.push_back(3'(n));
      wait_tick(1'b0, ok);
      eat_pulse(1'b0);
      exp = len_q.pop_front();
      checks++;
      if (!ok || length !== exp) begin
        failures++;
        $display("FAIL eat_%0d: len=%0d expected %0d tick=%0b", n, length, exp, ok);
      end
    end
    len_q.push_back(3'd6);
    wait_tick(1'b0, ok);
    head = 1'b1; apple = 1'b1;
    win_seen = 1'b0; win_ticks = 0; len_at_win = '0; dir_at_win = 4'hF;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK100MHZ);
      if (k == 2) begin head = 1'b0; apple = 1'b0; end
      if (!win_seen && i_speaker) begin
        win_seen = 1'b1; len_at_win = length; dir_at_win = direction;
      end else if (win_seen) begin
        if (update_clk) win_ticks++;
        if (!i_speaker) break;
      end
    end
    exp = len_q.pop_front();
    checks++;
    if (!win_seen || len_at_win !== exp || dir_at_win !== 4'b0000) begin
      failures++;
      $display("FAIL win_entry: seen=%0b len=%0d dir=%b expected 1/%0d/0000", win_seen, len_at_win, dir_at_win, exp);
    end
    checks++;
    if (win_ticks != 2 || i_speaker !== 1'b0) begin
      failures++;
      $display("FAIL win_hold: slow_ticks=%0d spk=%b expected 2/0", win_ticks, i_speaker);
    end
    checks++;
    if (length !== 3'd0 || direction !== 4'b0000) begin
      failures++;
      $display("FAIL win_to_idle: len=%0d dir=%b expected 0/0000", length, direction);
    end
  endtask

  task automatic test_over();
    bit ok;
    logic [3:0] exp;
    logic [2:0] exp_len;
    sw_level = 1'b1;
    press_btns(5'b10000, 5);
    dir_q.push_back(4'b0010);
    wait_tick(1'b1, ok);
    exp = dir_q.pop_front();
    checks++;
    if (!ok || direction !== exp || level !== 1'b1) begin
      failures++;
      $display("FAIL slow_start: dir=%b lvl=%b expected %b/1 tick=%0b", direction, level, exp, ok);
    end
    len_q.push_back(3'd1);
    eat_pulse(1'b0);
    exp_len = len_q.pop_front();
    checks++;
    if (length !== exp_len) begin
      failures++;
      $display("FAIL slow_eat: len=%0d expected %0d", length, exp_len);
    end
    len_q.push_back(3'd1);
    wait_tick(1'b1, ok);
    eat_pulse(1'b1);
    exp_len = len_q.pop_front();
    checks++;
    if (!ok || over !== 1'b1 || direction !== 4'b0000 || length !== exp_len) begin
      failures++;
      $display("FAIL over_entry: over=%b dir=%b len=%0d expected 1/0000/%0d", over, direction, length, exp_len);
    end
    press_btns(5'b10000, 5);
    checks++;
    if (over !== 1'b0 || length !== 3'd0 || direction !== 4'b0000) begin
      failures++;
      $display("FAIL over_exit: over=%b len=%0d dir=%b expected 0/0/0000", over, length, direction);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sw_level = 1'b1;
    press_btns(5'b10000, 5);
    for (int n = 1; n <= 3; n++) begin
      len_q.push_back(3'(n));
      wait_tick(1'b1, ok);
      eat_pulse(1'b0);
      void'(len_q.pop_front());
    end
    checks++;
    if (length !== 3'd3 || direction === 4'b0000) begin
      failures++;
      $display("FAIL pre_reset: len=%0d dir=%b expected 3/moving", length, direction);
    end
    btn_start = 1'b1;
    sw_level  = 1'b0;
    @(negedge CLK100MHZ);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (direction !== 4'b0000 || length !== 3'd0 || level !== 1'b1 || over !== 1'b0 ||
        i_speaker !== 1'b0 || update_clk !== 1'b0 || update_clk_fast !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: dir=%b len=%0d lvl=%b over=%b spk=%b uc=%b ucf=%b",
               direction, length, level, over, i_speaker, update_clk, update_clk_fast);
    end
    repeat (3) @(negedge CLK100MHZ);
    reset = 1'b0;
    repeat (12) @(negedge CLK100MHZ);
    btn_start = 1'b0;
    repeat (10) @(negedge CLK100MHZ);
    checks++;
    if (level !== 1'b1 || direction !== 4'b0000) begin
      failures++;
      $display("FAIL held_through_reset: lvl=%b dir=%b expected 1/0000", level, direction);
    end
    press_btns(5'b10000, 5);
    checks++;
    if (level !== 1'b0) begin
      failures++;
      $display("FAIL repress_start: lvl=%b expected 0", level);
    end
  endtask

  task automatic test_pause();
    bit ok;
    logic [3:0] exp;
    dir_q.push_back(4'b0010);
    wait_tick(1'b0, ok);
    exp = dir_q.pop_front();
    checks++;
    if (!ok || direction !== exp) begin
      failures++;
      $display("FAIL pre_pause: dir=%b expected %b tick=%0b", direction, exp, ok);
    end
    press_btns(5'b10000, 5);
`ifdef PAUSE_EN
    dir_q.push_back(4'b0000);
`else
    dir_q.push_back(4'b0010);
`endif
    wait_tick(1'b0, ok);
    exp = dir_q.pop_front();
    checks++;
    if (!ok || direction !== exp) begin
      failures++;
      $display("FAIL start_in_play: dir=%b expected %b tick=%0b", direction, exp, ok);
    end
`ifdef PAUSE_EN
    press_btns(5'b10000, 5);
    checks++;
    if (direction !== 4'b0010) begin
      failures++;
      $display("FAIL resume: dir=%b expected 0010", direction);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_start_fast();
    test_reverse();
    test_eat_win();
    test_over();
    test_reset_mid();
    test_pause();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1);
  end

endmodule
